// File: rtl/ppu_pkg.sv
// -----------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the PPU ID-stage control decode:
//   - MIPS32 opcode, funct and REGIMM rt codes
//   - ALU operation encodings (plain and shift-immediate)
//   - bit positions of the 15-bit control word and its typedef
//   - small helpers that build common control-word patterns
// -----------------------------------------------------------------------------
package ppu_pkg;

  typedef logic [14:0] ctrl_word_t;

  // Control-word bit positions
  localparam int unsigned CW_SHIFT_IMM  = 14;
  localparam int unsigned CW_ALU_OP_HI  = 13;
  localparam int unsigned CW_ALU_OP_LO  = 11;
  localparam int unsigned CW_LOAD_INSTR = 10;
  localparam int unsigned CW_RF_ENABLE  = 9;
  localparam int unsigned CW_BRANCH     = 8;
  localparam int unsigned CW_TA_INSTR   = 7;
  localparam int unsigned CW_MEM_SIZE_HI = 6;
  localparam int unsigned CW_MEM_SIZE_LO = 5;
  localparam int unsigned CW_MEM_RW     = 4;
  localparam int unsigned CW_MEM_SE     = 3;
  localparam int unsigned CW_HI_ENABLE  = 2;
  localparam int unsigned CW_LO_ENABLE  = 1;
  localparam int unsigned CW_MEM_ENABLE = 0;

  localparam ctrl_word_t CW_NOP = 15'h0000;

  // ALU operations (shift_imm = 0)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;
  // ALU operations (shift_imm = 1)
  localparam logic [2:0] ALU_SLL  = 3'b000;
  localparam logic [2:0] ALU_SRL  = 3'b001;
  localparam logic [2:0] ALU_SRA  = 3'b010;

  // Memory access sizes
  localparam logic [1:0] MSZ_BYTE = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_WORD = 2'b10;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Register-writing ALU operation (R-type and immediate arithmetic).
  function automatic ctrl_word_t cw_alu_rf(input logic [2:0] alu_op, input logic shift_imm);
    ctrl_word_t cw;
    cw = CW_NOP;
    cw[CW_SHIFT_IMM]               = shift_imm;
    cw[CW_ALU_OP_HI:CW_ALU_OP_LO]  = alu_op;
    cw[CW_RF_ENABLE]               = 1'b1;
    return cw;
  endfunction

  // Load or store through the ADD address path.
  function automatic ctrl_word_t cw_mem(input logic is_load, input logic [1:0] size,
                                        input logic sign_ext);
    ctrl_word_t cw;
    cw = CW_NOP;
    cw[CW_ALU_OP_HI:CW_ALU_OP_LO]     = ALU_ADD;
    cw[CW_LOAD_INSTR]                 = is_load;
    cw[CW_RF_ENABLE]                  = is_load;
    cw[CW_MEM_SIZE_HI:CW_MEM_SIZE_LO] = size;
    cw[CW_MEM_RW]                     = ~is_load;
    cw[CW_MEM_SE]                     = sign_ext;
    cw[CW_MEM_ENABLE]                 = 1'b1;
    return cw;
  endfunction

endpackage

// File: rtl/ppu_decoder.sv
// -----------------------------------------------------------------------------
// ppu_decoder
// Purely combinational MIPS32 instruction -> 15-bit control word decode.
// Unsupported encodings and the all-zero NOP produce an all-zero word.
// Optional feature macro: PPU_HILO_EN (MFHI/MFLO/MTHI/MTLO decode; when it is
// undefined those encodings decode to zero and hi/lo enables stay 0).
// Ports:
//   instr_i [31:0] - instruction word from IF/ID
//   ctrl_o  [14:0] - decoded control word
// -----------------------------------------------------------------------------
module ppu_decoder
  import ppu_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_word_t  ctrl_o
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign rt     = instr_i[20:16];
  assign funct  = instr_i[5:0];

  always_comb begin
    ctrl_o = CW_NOP;
    // The all-zero word would otherwise decode as SLL $0,$0,0.
    if (instr_i != 32'h0000_0000) begin
      unique case (opcode)
        OP_SPECIAL: begin
          unique case (funct)
            FN_ADD, FN_ADDU: ctrl_o = cw_alu_rf(ALU_ADD,  1'b0);
            FN_SUB, FN_SUBU: ctrl_o = cw_alu_rf(ALU_SUB,  1'b0);
            FN_AND:          ctrl_o = cw_alu_rf(ALU_AND,  1'b0);
            FN_OR:           ctrl_o = cw_alu_rf(ALU_OR,   1'b0);
            FN_XOR:          ctrl_o = cw_alu_rf(ALU_XOR,  1'b0);
            FN_NOR:          ctrl_o = cw_alu_rf(ALU_NOR,  1'b0);
            FN_SLT:          ctrl_o = cw_alu_rf(ALU_SLT,  1'b0);
            FN_SLTU:         ctrl_o = cw_alu_rf(ALU_SLTU, 1'b0);
            FN_SLL:          ctrl_o = cw_alu_rf(ALU_SLL,  1'b1);
            FN_SRL:          ctrl_o = cw_alu_rf(ALU_SRL,  1'b1);
            FN_SRA:          ctrl_o = cw_alu_rf(ALU_SRA,  1'b1);
            FN_JR: begin
              ctrl_o[CW_BRANCH] = 1'b1;
            end
            FN_JALR: begin
              ctrl_o[CW_BRANCH]    = 1'b1;
              ctrl_o[CW_RF_ENABLE] = 1'b1;
            end
`ifdef PPU_HILO_EN
            FN_MFHI, FN_MFLO: begin
              ctrl_o[CW_RF_ENABLE] = 1'b1;
            end
            FN_MTHI: begin
              ctrl_o[CW_HI_ENABLE] = 1'b1;
            end
            FN_MTLO: begin
              ctrl_o[CW_LO_ENABLE] = 1'b1;
            end
`endif
            default: ctrl_o = CW_NOP;
          endcase
        end
        OP_REGIMM: begin
          // BAL writes the link register; plain BLTZ/BGEZ do not.
          if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BGEZAL) begin
            ctrl_o[CW_BRANCH]                = 1'b1;
            ctrl_o[CW_ALU_OP_HI:CW_ALU_OP_LO] = ALU_SUB;
            ctrl_o[CW_RF_ENABLE]             = (rt == RT_BGEZAL);
          end
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
          ctrl_o[CW_BRANCH]                = 1'b1;
          ctrl_o[CW_ALU_OP_HI:CW_ALU_OP_LO] = ALU_SUB;
        end
        OP_J: begin
          ctrl_o[CW_BRANCH]   = 1'b1;
          ctrl_o[CW_TA_INSTR] = 1'b1;
        end
        OP_JAL: begin
          ctrl_o[CW_BRANCH]    = 1'b1;
          ctrl_o[CW_TA_INSTR]  = 1'b1;
          ctrl_o[CW_RF_ENABLE] = 1'b1;
        end
        OP_ADDI, OP_ADDIU: ctrl_o = cw_alu_rf(ALU_ADD,  1'b0);
        OP_SLTI:           ctrl_o = cw_alu_rf(ALU_SLT,  1'b0);
        OP_SLTIU:          ctrl_o = cw_alu_rf(ALU_SLTU, 1'b0);
        OP_ANDI:           ctrl_o = cw_alu_rf(ALU_AND,  1'b0);
        // LUI is executed as OR of the shifted immediate with zero.
        OP_ORI, OP_LUI:    ctrl_o = cw_alu_rf(ALU_OR,   1'b0);
        OP_XORI:           ctrl_o = cw_alu_rf(ALU_XOR,  1'b0);
        OP_LB:             ctrl_o = cw_mem(1'b1, MSZ_BYTE, 1'b1);
        OP_LBU:            ctrl_o = cw_mem(1'b1, MSZ_BYTE, 1'b0);
        OP_LH:             ctrl_o = cw_mem(1'b1, MSZ_HALF, 1'b1);
        OP_LHU:            ctrl_o = cw_mem(1'b1, MSZ_HALF, 1'b0);
        OP_LW:             ctrl_o = cw_mem(1'b1, MSZ_WORD, 1'b0);
        OP_SB:             ctrl_o = cw_mem(1'b0, MSZ_BYTE, 1'b0);
        OP_SH:             ctrl_o = cw_mem(1'b0, MSZ_HALF, 1'b0);
        OP_SW:             ctrl_o = cw_mem(1'b0, MSZ_WORD, 1'b0);
        default:           ctrl_o = CW_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ppu_control_unit.sv
// -----------------------------------------------------------------------------
// ppu_control_unit
// ID-stage control unit of the PPU 5-stage MIPS pipeline. Decodes the current
// instruction combinationally and registers the result into the ID/EX stage.
// Optional feature macro: PPU_HILO_EN (passed through to ppu_decoder).
// Ports:
//   clk            - rising-edge clock
//   reset          - synchronous, active-low; clears control_q
//   instruction    - [31:0] instruction from IF/ID
//   flush          - inserts a NOP into control_q at the next edge
//   control_output - [14:0] combinational decode of instruction
//   control_q      - [14:0] registered control word for the EX stage
// -----------------------------------------------------------------------------
module ppu_control_unit
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        flush,
  output logic [14:0] control_output,
  output logic [14:0] control_q
);

  ctrl_word_t dec_ctrl;
  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_q;

  ppu_decoder u_decoder (
    .instr_i (instruction),
    .ctrl_o  (dec_ctrl)
  );

  // Flush turns the outgoing word into a bubble; reset is handled in the register.
  always_comb begin
    ctrl_d = dec_ctrl;
    if (flush) begin
      ctrl_d = CW_NOP;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= CW_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign control_output = dec_ctrl;
  assign control_q      = ctrl_q;

endmodule

// File: tb/tb_ppu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_ppu_control_unit
// Scoreboard bench: each applied instruction is checked combinationally, and
// the expected registered word is queued and compared one edge later.
// Honors PPU_HILO_EN for the HI/LO instruction expectations.
// -----------------------------------------------------------------------------
module tb_ppu_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        flush;
  logic [14:0] control_output;
  logic [14:0] control_q;

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_q[$];

  ppu_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .flush          (flush),
    .control_output (control_output),
    .control_q      (control_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational word, queue the
  // expected registered word and compare it after the following edge.
  task automatic step(input string tag, input logic [31:0] ins, input logic fl,
                      input logic rst_n, input logic [14:0] exp_comb);
    logic [14:0] e;
    @(negedge clk);
    instruction = ins;
    flush       = fl;
    reset       = rst_n;
    #1;
    chk({tag, "/comb"}, control_output, exp_comb);
    exp_q.push_back((!rst_n || fl) ? 15'h0000 : exp_comb);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s/reg: scoreboard empty, got 0x%04h", tag, control_q);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/reg"}, control_q, e);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [14:0] exp;
  } vec_t;

`ifdef PPU_HILO_EN
  localparam logic [14:0] E_MTHI = 15'h0004;
  localparam logic [14:0] E_MTLO = 15'h0002;
  localparam logic [14:0] E_MFHL = 15'h0200;
`else
  localparam logic [14:0] E_MTHI = 15'h0000;
  localparam logic [14:0] E_MTLO = 15'h0000;
  localparam logic [14:0] E_MFHL = 15'h0000;
`endif

  vec_t vecs[$];

  initial begin
    instruction = 32'h0;
    flush       = 1'b0;
    reset       = 1'b0;

    vecs = '{
      '{"addu",  32'h00221821, 15'h0200},
      '{"add",   32'h00221820, 15'h0200},
      '{"subu",  32'h00221823, 15'h0A00},
      '{"and",   32'h00221824, 15'h1200},
      '{"or",    32'h00221825, 15'h1A00},
      '{"xor",   32'h00221826, 15'h2200},
      '{"nor",   32'h00221827, 15'h2A00},
      '{"slt",   32'h0022182A, 15'h3200},
      '{"sltu",  32'h0022182B, 15'h3A00},
      '{"sll",   32'h00011100, 15'h4200},
      '{"srl",   32'h00011102, 15'h4A00},
      '{"sra",   32'h00011103, 15'h5200},
      '{"nop",   32'h00000000, 15'h0000},
      '{"addi",  32'h20220004, 15'h0200},
      '{"slti",  32'h28220004, 15'h3200},
      '{"sltiu", 32'h2C220004, 15'h3A00},
      '{"andi",  32'h30220004, 15'h1200},
      '{"ori",   32'h34220004, 15'h1A00},
      '{"xori",  32'h38220004, 15'h2200},
      '{"lui",   32'h3C020004, 15'h1A00},
      '{"lw",    32'h8C220004, 15'h0641},
      '{"lb",    32'h80220004, 15'h0609},
      '{"lbu",   32'h90220004, 15'h0601},
      '{"lh",    32'h84220004, 15'h0629},
      '{"lhu",   32'h94220004, 15'h0621},
      '{"sb",    32'hA0220004, 15'h0011},
      '{"sh",    32'hA4220004, 15'h0031},
      '{"sw",    32'hAC220004, 15'h0051},
      '{"beq",   32'h10220003, 15'h0900},
      '{"bne",   32'h14220003, 15'h0900},
      '{"blez",  32'h18200003, 15'h0900},
      '{"bltz",  32'h04200003, 15'h0900},
      '{"bgez",  32'h04210003, 15'h0900},
      '{"bal",   32'h04310003, 15'h0B00},
      '{"rgbad", 32'h04300003, 15'h0000},
      '{"j",     32'h08000010, 15'h0180},
      '{"jal",   32'h0C000010, 15'h0380},
      '{"jr",    32'h00200008, 15'h0100},
      '{"jalr",  32'h0020F809, 15'h0300},
      '{"illop", 32'hFC000000, 15'h0000},
      '{"illfn", 32'h00221801, 15'h0000},
      '{"mthi",  32'h00200011, E_MTHI},
      '{"mtlo",  32'h00200013, E_MTLO},
      '{"mfhi",  32'h00001810, E_MFHL},
      '{"mflo",  32'h00001812, E_MFHL}
    };

    // Reset: register cleared while decode still follows the instruction.
    step("rst0", 32'h00000000, 1'b0, 1'b0, 15'h0000);
    step("rst1", 32'h8C220004, 1'b0, 1'b0, 15'h0641);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].ins, 1'b0, 1'b1, vecs[i].exp);
    end

    // Hold LW: flush bubble, recovery, mid-stream reset, reset+flush, release.
    step("lw_a",   32'h8C220004, 1'b0, 1'b1, 15'h0641);
    step("flush",  32'h8C220004, 1'b1, 1'b1, 15'h0641);
    step("lw_b",   32'h8C220004, 1'b0, 1'b1, 15'h0641);
    step("rstmid", 32'h8C220004, 1'b0, 1'b0, 15'h0641);
    step("rstfl",  32'h8C220004, 1'b1, 1'b0, 15'h0641);
    step("lw_c",   32'h8C220004, 1'b0, 1'b1, 15'h0641);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
